// File: rtl/data_mem_bridge.sv
// data_mem_bridge: CPU data-port to data-memory handshake bridge with timeout abort and sticky bus error.
module data_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_byteenable,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]  state;
  logic [15:0] cnt;
  logic        req, bad, tmo;
  assign req = cpu_read | cpu_write;
  assign bad = (cpu_read & cpu_write) | (cpu_byteenable == 4'd0);
  // Expiry fires in the BUSY cycle that would make the count reach TIMEOUT_CYCLES.
  assign tmo = cnt == 16'(TIMEOUT_CYCLES - 1);
  assign cpu_waitrequest = state == IDLE ? req : state == BUSY;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      cpu_readdata <= '0;
      bus_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          if (bad) begin
            bus_error    <= 1'b1;
            cpu_readdata <= '0;
            state        <= DONE;
          end else begin
            mem_address <= cpu_address & 32'hFFFF_FFFC;
            mem_wdata   <= cpu_writedata;
            mem_be      <= cpu_byteenable;
            mem_we      <= cpu_write;
            mem_req     <= 1'b1;
            cnt         <= '0;
            state       <= BUSY;
          end
        end
        BUSY: if (mem_ack) begin
          if (!mem_we) cpu_readdata <= mem_rdata;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= DONE;
        end else if (tmo) begin
          bus_error    <= 1'b1;
          cpu_readdata <= '0;
          mem_req      <= 1'b0;
          mem_we       <= 1'b0;
          state        <= DONE;
        end else begin
          cnt <= cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/data_mem_bridge.md
DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum BUSY cycles without mem_ack before abort (legal range 1..65535).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 cpu_address  input  32  CPU data-port byte address.
REQ-005 cpu_read / cpu_write  input  1 each  CPU load / store request, held by CPU while cpu_waitrequest=1.
REQ-006 cpu_writedata  input  32  store data; cpu_byteenable  input  4  active lanes, bit0 = bits 7:0.
REQ-007 cpu_readdata  output  32  load result, valid only in the cycle cpu_waitrequest falls after a read.
REQ-008 cpu_waitrequest  output  1  stall to CPU.
REQ-009 mem_req  output  1  request to data memory; mem_we  output  1  write strobe qualifier.
REQ-010 mem_address  output  32  word address {cpu_address[31:2],2'b00}; mem_wdata  output  32; mem_be  output  4.
REQ-011 mem_ack  input  1  memory completion; mem_rdata  input  32  read data, valid with mem_ack.
REQ-012 bus_error  output  1  sticky error flag.

Function
REQ-013 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 IDLE: cpu_waitrequest = cpu_read | cpu_write (combinational); otherwise 0.
REQ-015 IDLE with exactly one of cpu_read/cpu_write high and cpu_byteenable != 0: capture address, writedata, byteenable, direction; next state BUSY.
REQ-016 IDLE with cpu_read & cpu_write both high, or cpu_byteenable == 0: no memory access, bus_error <= 1, readdata reg <= 0, next state DONE.
REQ-017 BUSY: mem_req=1 (registered, held constant), mem_we=1 for writes, mem_address/mem_wdata/mem_be from captured values; cpu_waitrequest=1.
REQ-018 BUSY, mem_ack sampled high: readdata reg <= mem_rdata (reads only, writes leave it unchanged), mem_req drops next cycle, next state DONE.
REQ-019 BUSY timeout counter clears on BUSY entry, increments each BUSY cycle without ack; on reaching TIMEOUT_CYCLES: bus_error <= 1, readdata reg <= 0, next state DONE.
REQ-020 mem_ack and timeout in same cycle: ack wins, no error.
REQ-021 DONE: cpu_waitrequest=0 for exactly one cycle, cpu_readdata = readdata reg, mem_req=0; next state IDLE unconditionally.
REQ-022 Minimum latency: request in cycle N, mem_ack in N+1 -> cpu_waitrequest low in N+2.
REQ-023 mem_ack while mem_req=0 ignored.
REQ-024 Back-to-back requests: new request accepted only in IDLE; at least one IDLE cycle between transactions.
REQ-025 cpu_readdata holds last value outside DONE; CPU changes to request inputs during BUSY ignored (captured values used).
REQ-026 bus_error cleared only by reset.

Reset
REQ-027 reset=0 forces immediately (asynchronously): state IDLE, mem_req=0, mem_we=0, mem_address=0, mem_wdata=0, mem_be=0, cpu_readdata=0, bus_error=0, timeout counter 0.
REQ-028 Reset asserted in BUSY aborts transaction; no DONE cycle issued after release; memory discards the dropped request.
REQ-029 After reset release, first request accepted on the first rising edge in IDLE.

Verification
REQ-030 Read addr 0x00000007, be=1111, mem_ack one cycle after mem_req, mem_rdata=0x55010101 -> mem_address=0x00000004, cpu_waitrequest low 2 cycles after request, cpu_readdata=0x55010101.
REQ-031 Write addr 0x00000010, data 0xDEADBEEF, be=0011, ack after 3 cycles -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF for 3 cycles, waitrequest low in cycle 5, bus_error=0.
REQ-032 TIMEOUT_CYCLES=4, read, no ack -> mem_req high 4 cycles then low, DONE with cpu_readdata=0, bus_error=1 and stays 1.
REQ-033 cpu_read=cpu_write=1 -> mem_req never asserts, waitrequest low next cycle, bus_error=1.
REQ-034 reset pulled low in 2nd BUSY cycle -> mem_req and all outputs 0 same cycle; after release, read of 0x00000000 with ack completes normally.
REQ-035 mem_ack asserted in same cycle as timeout expiry -> data returned, bus_error=0.
